ix_scoreboard: RTL
==================

Name: ix_scoreboard

Overview:
- Parametrised register file plus scoreboard for the issue stage.
- Replaces the fixed two-read, fixed-priority writeback arrangement with:
  - NRD read ports;
  - NWB writeback ports, arbitrated round-robin;
  - a per-register busy bit set at issue and cleared at writeback.
- Sits between decode and the functional-unit pipes. Issue logic queries operand readiness and values here and reports each issued destination.

Parameters:
XLEN, 64, data width of registers and writeback values
NRD, 2, number of read (operand) ports
NWB, 2, number of writeback ports (FU result channels)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
rd_addr  input  NRD*5  read port addresses; port k uses bits [5k+4:5k]
rd_value  output  NRD*XLEN  read data per port (combinational)
rd_ready  output  NRD  operand available per port (combinational)
iss_valid  input  1  issue of an instruction this cycle
iss_wb_en  input  1  issued instruction writes a register
iss_rd  input  5  issued destination register
iss_ready  output  1  destination free; issue may complete
wb_valid  input  NWB  writeback request per port
wb_dst  input  NWB*5  writeback destination per port
wb_value  input  NWB*XLEN  writeback data per port
wb_ready  output  NWB  writeback accepted (one-hot or zero)

Behaviour:
- Reset:
  - busy[31:1] cleared; round-robin pointer = 0; wb_ready = 0 while rst is high.
  - Register contents are not reset.
  - Reset asserted mid-operation discards all pending busy state. Any wb_valid held across reset is accepted normally after reset.
- Register x0:
  - reads 0 and is always ready;
  - is never marked busy;
  - writebacks to x0 are accepted (wb_ready pulses) and discarded.
- Writeback arbitration:
  - At most one port is granted per cycle. The grant goes to the first valid port at or after the pointer, scanning upward with wrap modulo NWB.
  - wb_ready[g] = 1 combinationally, only for the granted port.
  - On grant: rf[dst] <= value; busy[dst] <= 0; pointer <= (g+1) mod NWB.
  - With no valid port, the pointer holds.
  - Non-granted ports keep valid, dst and value stable until granted (valid/ready handshake).
- Issue:
  - iss_ready = !(iss_wb_en && iss_rd != 0 && busy[iss_rd] && !clr), where clr = a writeback to iss_rd is granted this cycle.
  - Result: at most one outstanding write per register, so WAW is blocked.
  - iss_valid && iss_ready && iss_wb_en && iss_rd != 0 sets busy[iss_rd] next cycle.
  - If set and clear hit the same register in the same cycle, set wins: busy stays 1 and the new write is outstanding.
  - iss_valid with iss_ready = 0 has no effect on state.
- Read port k, in priority order:
  1. addr = 0 -> value 0, ready 1.
  2. busy[addr] and some port j has wb_valid[j] with wb_dst[j] = addr -> value wb_value[j], ready 1 (forward from the request, granted or not). Uniqueness is guaranteed by the WAW rule.
  3. busy[addr] and no matching valid port -> ready 0, value don't-care.
  4. Not busy -> rf[addr], ready 1.
- Latency:
  - a write is visible in rf the cycle after grant;
  - it is forwarded in the cycle it is presented.
- Reads are purely combinational, with no internal pipeline registers apart from rf, busy and the pointer.

Test Plan:
- Reset, then grant wb port0 dst=5 value=0x1234 -> wb_ready=01. Next cycle rd_addr[0]=5 gives rd_value 0x1234, rd_ready 1.
- Issue iss_rd=7 -> next cycle rd_addr=7 gives rd_ready 0. Present wb port1 dst=7 value=0xAA -> same cycle rd_ready 1, rd_value 0xAA. Following cycle busy[7]=0.
- Both ports valid for 4 cycles with distinct dst:
  - wb_ready must sequence 01,10 and then stop once both are drained;
  - with fresh requests each cycle, the grant must alternate 01,10,01,10.
- iss_rd=9 while 9 is busy with no writeback -> iss_ready 0, no state change. Same cycle with a writeback to 9 granted -> iss_ready 1, and busy[9] stays 1 afterward.
- Writeback dst=0 value=0xFF -> accepted. rd_addr=0 reads 0, ready 1. Issue to rd=0 -> iss_ready 1, no busy set.
- Set busy on x3, assert rst for 1 cycle -> rd_addr=3 ready 1, wb_ready all 0 during reset, pointer back to port0.

Source files
------------

// File: rtl/ix_scoreboard_if.sv
// Operand-read, issue and writeback bundle between issue logic and the scoreboard.
// Latency: pure wiring, no storage.
// Backpressure: wb_ready is the per-port handshake and iss_ready gates issue.
//
// Ports (master = issue/FU side, slave = scoreboard):
//   rd_addr/rd_value/rd_ready : NRD operand read ports
//   iss_valid/iss_wb_en/iss_rd/iss_ready : destination reservation at issue
//   wb_valid/wb_dst/wb_value/wb_ready : NWB writeback channels
interface ix_scoreboard_if #(
  parameter int XLEN = 64,
  parameter int NRD  = 2,
  parameter int NWB  = 2
) ();
  logic [NRD*5-1:0]    rd_addr;
  logic [NRD*XLEN-1:0] rd_value;
  logic [NRD-1:0]      rd_ready;

  logic                iss_valid;
  logic                iss_wb_en;
  logic [4:0]          iss_rd;
  logic                iss_ready;

  logic [NWB-1:0]      wb_valid;
  logic [NWB*5-1:0]    wb_dst;
  logic [NWB*XLEN-1:0] wb_value;
  logic [NWB-1:0]      wb_ready;

  modport master (
    output rd_addr, iss_valid, iss_wb_en, iss_rd, wb_valid, wb_dst, wb_value,
    input  rd_value, rd_ready, iss_ready, wb_ready
  );

  modport slave (
    input  rd_addr, iss_valid, iss_wb_en, iss_rd, wb_valid, wb_dst, wb_value,
    output rd_value, rd_ready, iss_ready, wb_ready
  );
endinterface

// File: rtl/ix_scoreboard.sv
// Register file plus per-register busy scoreboard with round-robin writeback arbitration.
// Latency: reads/forwarding combinational; a granted write lands in rf the next cycle.
// Backpressure: one writeback granted per cycle via wb_ready; iss_ready drops on WAW.
//
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset (clears busy and pointer, not rf)
//   sb  : ix_scoreboard_if slave modport (read, issue and writeback channels)
module ix_scoreboard #(
  parameter int XLEN = 64,
  parameter int NRD  = 2,
  parameter int NWB  = 2
) (
  input logic             clk,
  input logic             rst,
  ix_scoreboard_if.slave  sb
);

  localparam int PW = (NWB > 1) ? $clog2(NWB) : 1;

  logic [XLEN-1:0] rf_q [32];
  logic [31:0]     busy_q, busy_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      gnt_dst;
  logic [XLEN-1:0] gnt_val;
  logic            wb_acc;
  logic [NWB-1:0]  wb_gnt;
  logic            iss_clr;
  logic            iss_rdy;
  logic            iss_set;

  logic [4:0]          rd_a [NRD];
  logic [NRD*XLEN-1:0] rd_val;
  logic [NRD-1:0]      rd_rdy;

  // Round-robin: first valid port at or after the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NWB; i++) begin
      if (!gnt_vld && sb.wb_valid[(int'(ptr_q) + i) % NWB]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(ptr_q) + i) % NWB);
      end
    end
  end

  assign gnt_dst = sb.wb_dst[5*int'(gnt_idx) +: 5];
  assign gnt_val = sb.wb_value[XLEN*int'(gnt_idx) +: XLEN];

  // Nothing is accepted while reset is held, so a request held across
  // reset is still pending (and granted) afterwards.
  assign wb_acc = gnt_vld && !rst;

  always_comb begin
    wb_gnt = '0;
    if (wb_acc) begin
      wb_gnt[gnt_idx] = 1'b1;
    end
  end

  assign sb.wb_ready = wb_gnt;

  // A destination being freed by this cycle's grant may be reissued at once.
  assign iss_clr = wb_acc && (gnt_dst == sb.iss_rd);
  assign iss_rdy = !(sb.iss_wb_en && (sb.iss_rd != 5'd0) && busy_q[sb.iss_rd] && !iss_clr);
  assign iss_set = sb.iss_valid && iss_rdy && sb.iss_wb_en && (sb.iss_rd != 5'd0);
  assign sb.iss_ready = iss_rdy;

  // Clear before set: a same-cycle set on the register being written back
  // wins, leaving the new write outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wb_acc) begin
      busy_d[gnt_dst] = 1'b0;
    end
    if (iss_set) begin
      busy_d[sb.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (wb_acc) begin
      ptr_d = (int'(gnt_idx) == NWB - 1) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      ptr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  // Register contents survive reset; x0 writes are dropped.
  always_ff @(posedge clk) begin
    if (wb_acc && (gnt_dst != 5'd0)) begin
      rf_q[gnt_dst] <= gnt_val;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd_addr
    assign rd_a[k] = sb.rd_addr[5*k +: 5];
  end

  // Forward from any matching writeback request, granted or not. The WAW
  // block guarantees at most one valid request per busy register.
  always_comb begin
    rd_val = '0;
    rd_rdy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_a[k] == 5'd0) begin
        rd_rdy[k] = 1'b1;
      end else if (busy_q[rd_a[k]]) begin
        for (int j = 0; j < NWB; j++) begin
          if (sb.wb_valid[j] && (sb.wb_dst[5*j +: 5] == rd_a[k])) begin
            rd_val[XLEN*k +: XLEN] = sb.wb_value[XLEN*j +: XLEN];
            rd_rdy[k]              = 1'b1;
          end
        end
      end else begin
        rd_val[XLEN*k +: XLEN] = rf_q[rd_a[k]];
        rd_rdy[k]              = 1'b1;
      end
    end
  end

  assign sb.rd_value = rd_val;
  assign sb.rd_ready = rd_rdy;

endmodule
